nonce_sweep_ctrl: RTL
=====================

# nonce_sweep_ctrl

Sequencer that drives the double-SHA-256 header engine across a nonce range. It latches a 76-byte header prefix, target and nonce range, then issues one engine job per nonce and byte-reverses and compares each digest against the target. It stops on the first hit, range exhaustion, abort, or engine timeout. It sits between the host/config logic and the engine's start/blockHeader/digest/finish ports.

## Interface
- WATCHDOG_CYCLES, 4096: maximum cycles from eng_start to eng_finish before a timeout is declared.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- start  in  1  job request strobe, accepted only in IDLE.
- abort  in  1  stop request, honoured in any non-IDLE state.
- prefix  in  608  header bytes 0..75 in wire order; sampled on accepted start.
- target  in  256  unsigned threshold; sampled on accepted start.
- nonce_start  in  32  first nonce; sampled on accepted start.
- nonce_end  in  32  last nonce, inclusive; sampled on accepted start.
- eng_start  out  1  one-cycle engine start pulse.
- eng_header  out  640  {prefix_q, bswap32(nonce_cur)}, held stable from ISSUE through eng_finish.
- eng_digest  in  256  engine result, valid in the eng_finish cycle.
- eng_finish  in  1  engine completion strobe, one cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in the DONE state.
- status  out  2  00 exhausted, 01 found, 10 aborted, 11 timeout; valid from done until the next accepted start.
- found_nonce  out  32  nonce of the hit, native integer order.
- found_hash  out  256  byte-reversed digest of the hit.
- hashes_done  out  33  count of digests compared during the current job.

## Operation
- Reset: all outputs, eng_header and every register go to 0; state goes to IDLE.
- FSM states: IDLE, ISSUE, WAIT, CHECK, DONE.
- IDLE, on start: latch prefix_q, target_q, nonce_cur=nonce_start and end_q; clear hashes_done, status, found_nonce and found_hash; go to ISSUE. abort is ignored in IDLE, and start wins if both arrive in the same cycle.
- start while busy is ignored.
- ISSUE: assert eng_start, clear the watchdog, go to WAIT.
- WAIT: on eng_finish, register the digest and go to CHECK. If the watchdog reaches WATCHDOG_CYCLES first, set status=11 and go to DONE.
- CHECK: compute hash = bswap256(digest) and increment hashes_done.
  - If hash <= target_q (equality counts as a hit): status=01, found_nonce=nonce_cur, found_hash=hash; go to DONE.
  - Else, if nonce_cur == end_q: status=00; go to DONE.
  - Else: nonce_cur = nonce_cur+1 mod 2^32; go to ISSUE.
- Priority on the last nonce: a hit beats exhaustion.
- Range wraps. nonce_end < nonce_start sweeps through 0xFFFFFFFF to 0. start == end runs one nonce. 0 to 0xFFFFFFFF runs 2^32 nonces, so hashes_done reaches 2^32.
- abort in ISSUE or CHECK: status=10; go to DONE without issuing or comparing further.
- abort in WAIT: set abort_pend and stay in WAIT until eng_finish or timeout, so no stale finish leaks into a later job. On exit, status=10 (timeout still reports 11), the digest is discarded, and hashes_done is not incremented.
- abort coincident with eng_finish: treated as abort.
- DONE: pulse done and return to IDLE. Results hold.
- eng_finish outside WAIT is ignored.
- Asynchronous reset mid-job returns to IDLE immediately. An engine finish arriving after reset is ignored.

## Timing
- Accepted start at cycle 0 puts ISSUE (eng_start high) at cycle 1.
- With engine latency L (eng_start cycle to eng_finish cycle): CHECK occurs at t+L+1 and the next ISSUE at t+L+2, giving a per-nonce period of L+2.
- done rises the cycle after the final CHECK and stays high one cycle; busy falls the cycle after done.
- A timeout fires when the watchdog counter, cleared in ISSUE and incremented each WAIT cycle, reaches WATCHDOG_CYCLES.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package mining_pkg holds:
  - the state_t and status_t enums;
  - PREFIX_W=608, HEADER_W=640, DIGEST_W=256;
  - functions bswap32 and bswap256.
- One sub-module, target_compare: combinational bswap256 plus a 256-bit unsigned <= against target, registered at the CHECK boundary.
- The engine stays external; the integration wrapper connects it.

## Test plan
- Genesis header: prefix = genesis bytes 0..75, target = 0x00000000FFFF followed by 208 zero bits, range 0x7C2BAC1A..0x7C2BAC20, real engine. Required: status=01, found_nonce=0x7C2BAC1D, found_hash=0x000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f, hashes_done=4.
- Wrap: scripted engine model (L=10, digest all-ones), target=0, range 0xFFFFFFFE..0x00000001. Required: eng_header nonce bytes FEFFFFFF, FFFFFFFF, 00000000, 01000000 in that order; status=00; hashes_done=4; done at cycle 1+4*12.
- Abort in WAIT at cycle 5 (L=10). Required: no further eng_start; done one cycle after eng_finish; status=10; hashes_done=0.
- Timeout: WATCHDOG_CYCLES=64 and the model never finishes. Required: status=11 and done exactly 65 cycles after eng_start. A late eng_finish must not change state or results.
- start while busy, plus start coincident with abort in IDLE. Required: the busy start is ignored with latched fields unchanged; the IDLE start is accepted.
- Reset low mid-WAIT. Required: busy=0, status=0, eng_header=0 immediately. A subsequent eng_finish is ignored, and a new start runs normally.

Source files
------------

// File: rtl/mining_pkg.sv
// Shared types, widths and byte-order helpers for the nonce sweep sequencer
// and its digest comparator.
package mining_pkg;

  localparam int PREFIX_W = 608;
  localparam int HEADER_W = 640;
  localparam int DIGEST_W = 256;
  localparam int NONCE_W  = 32;
  localparam int COUNT_W  = 33;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    STAT_EXHAUSTED = 2'b00,
    STAT_FOUND     = 2'b01,
    STAT_ABORTED   = 2'b10,
    STAT_TIMEOUT   = 2'b11
  } status_t;

  function automatic logic [31:0] bswap32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = v[8*(3-i) +: 8];
    end
    return r;
  endfunction

  // Digests come out of the engine in wire order; the numeric hash is the
  // byte-reversed value.
  function automatic logic [DIGEST_W-1:0] bswap256(input logic [DIGEST_W-1:0] v);
    logic [DIGEST_W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGEST_W/8; i++) begin
      r[8*i +: 8] = v[DIGEST_W-8-8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/target_compare.sv
// Combinational digest-to-hash byte reversal and unsigned threshold compare;
// the sequencer registers the result when it leaves CHECK.
module target_compare
  import mining_pkg::*;
(
  input  logic [DIGEST_W-1:0] digest,
  input  logic [DIGEST_W-1:0] target,
  output logic [DIGEST_W-1:0] hash,
  output logic                hit
);

  always_comb begin
    hash = bswap256(digest);
    // Equality counts as a hit.
    hit  = (hash <= target);
  end

endmodule

// File: rtl/nonce_sweep_ctrl.sv
// Sweeps a nonce range through an external double-SHA-256 header engine,
// stopping on the first digest at or below target, exhaustion, abort or timeout.
module nonce_sweep_ctrl
  import mining_pkg::*;
#(
  parameter int WATCHDOG_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [PREFIX_W-1:0] prefix,
  input  logic [DIGEST_W-1:0] target,
  input  logic [NONCE_W-1:0]  nonce_start,
  input  logic [NONCE_W-1:0]  nonce_end,
  output logic                eng_start,
  output logic [HEADER_W-1:0] eng_header,
  input  logic [DIGEST_W-1:0] eng_digest,
  input  logic                eng_finish,
  output logic                busy,
  output logic                done,
  output logic [1:0]          status,
  output logic [NONCE_W-1:0]  found_nonce,
  output logic [DIGEST_W-1:0] found_hash,
  output logic [COUNT_W-1:0]  hashes_done
);

  localparam int          WD_W    = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

  state_t                state_reg;
  status_t               status_reg;
  logic [PREFIX_W-1:0]   prefix_reg;
  logic [DIGEST_W-1:0]   target_reg;
  logic [NONCE_W-1:0]    nonce_reg;
  logic [NONCE_W-1:0]    end_reg;
  logic [DIGEST_W-1:0]   digest_reg;
  logic [WD_W-1:0]       wd_reg;
  logic                  abort_pend_reg;
  logic                  eng_start_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic [NONCE_W-1:0]    found_nonce_reg;
  logic [DIGEST_W-1:0]   found_hash_reg;
  logic [COUNT_W-1:0]    hashes_done_reg;

  logic [DIGEST_W-1:0]   cmp_hash;
  logic                  cmp_hit;

  target_compare u_cmp (
    .digest (digest_reg),
    .target (target_reg),
    .hash   (cmp_hash),
    .hit    (cmp_hit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= S_IDLE;
      status_reg      <= STAT_EXHAUSTED;
      prefix_reg      <= '0;
      target_reg      <= '0;
      nonce_reg       <= '0;
      end_reg         <= '0;
      digest_reg      <= '0;
      wd_reg          <= '0;
      abort_pend_reg  <= 1'b0;
      eng_start_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      found_nonce_reg <= '0;
      found_hash_reg  <= '0;
      hashes_done_reg <= '0;
    end else begin
      eng_start_reg <= 1'b0;
      done_reg      <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          // abort is meaningless here, so a coincident start simply wins.
          if (start) begin
            prefix_reg      <= prefix;
            target_reg      <= target;
            nonce_reg       <= nonce_start;
            end_reg         <= nonce_end;
            hashes_done_reg <= '0;
            status_reg      <= STAT_EXHAUSTED;
            found_nonce_reg <= '0;
            found_hash_reg  <= '0;
            abort_pend_reg  <= 1'b0;
            busy_reg        <= 1'b1;
            eng_start_reg   <= 1'b1;
            state_reg       <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          wd_reg <= '0;
          if (abort) begin
            status_reg <= STAT_ABORTED;
            done_reg   <= 1'b1;
            state_reg  <= S_DONE;
          end else begin
            state_reg <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (eng_finish) begin
            // A pending or coincident abort discards the digest uncounted.
            if (abort || abort_pend_reg) begin
              status_reg <= STAT_ABORTED;
              done_reg   <= 1'b1;
              state_reg  <= S_DONE;
            end else begin
              digest_reg <= eng_digest;
              state_reg  <= S_CHECK;
            end
          end else if (wd_reg == WD_LAST) begin
            // This WAIT cycle brings the count to WATCHDOG_CYCLES.
            status_reg <= STAT_TIMEOUT;
            done_reg   <= 1'b1;
            state_reg  <= S_DONE;
          end else begin
            wd_reg <= wd_reg + WD_W'(1);
            if (abort) begin
              abort_pend_reg <= 1'b1;
            end
          end
        end

        S_CHECK: begin
          if (abort) begin
            status_reg <= STAT_ABORTED;
            done_reg   <= 1'b1;
            state_reg  <= S_DONE;
          end else begin
            hashes_done_reg <= hashes_done_reg + COUNT_W'(1);
            if (cmp_hit) begin
              status_reg      <= STAT_FOUND;
              found_nonce_reg <= nonce_reg;
              found_hash_reg  <= cmp_hash;
              done_reg        <= 1'b1;
              state_reg       <= S_DONE;
            end else if (nonce_reg == end_reg) begin
              status_reg <= STAT_EXHAUSTED;
              done_reg   <= 1'b1;
              state_reg  <= S_DONE;
            end else begin
              nonce_reg     <= nonce_reg + NONCE_W'(1);
              eng_start_reg <= 1'b1;
              state_reg     <= S_ISSUE;
            end
          end
        end

        S_DONE: begin
          // The job has already resolved; a late abort has nothing to stop.
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end

        default: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign eng_start   = eng_start_reg;
  assign eng_header  = {prefix_reg, bswap32(nonce_reg)};
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign status      = status_reg;
  assign found_nonce = found_nonce_reg;
  assign found_hash  = found_hash_reg;
  assign hashes_done = hashes_done_reg;

endmodule
